// File: rtl/arbitro_pkg.sv
// arbitro_pkg
// Shared constants for the two-player turn scheduler: FSM state codes, winner
// codes, and helpers for the turn-timer width and the winner decision.
package arbitro_pkg;

    // FSM state codes (also exported on db_estado)
    localparam logic [2:0] ST_OCIOSO  = 3'd0;
    localparam logic [2:0] ST_NOVA    = 3'd1;
    localparam logic [2:0] ST_ESPERA  = 3'd2;
    localparam logic [2:0] ST_ENVIA   = 3'd3;
    localparam logic [2:0] ST_AVALIA  = 3'd4;
    localparam logic [2:0] ST_PROXIMO = 3'd5;
    localparam logic [2:0] ST_FIM     = 3'd6;

    // Winner codes
    localparam logic [1:0] VENC_NENHUM = 2'b00;
    localparam logic [1:0] VENC_J1     = 2'b01;
    localparam logic [1:0] VENC_J2     = 2'b10;
    localparam logic [1:0] VENC_EMPATE = 2'b11;

    // Turn-timer width: $clog2(ciclos) bits hold 0..ciclos-1
    function automatic int unsigned largura_timer(input int unsigned ciclos);
        return (ciclos < 2) ? 1 : $clog2(ciclos);
    endfunction

    function automatic logic [1:0] calcula_vencedor(input logic [3:0] p1,
                                                    input logic [3:0] p2);
        if (p1 > p2) begin
            return VENC_J1;
        end else if (p2 > p1) begin
            return VENC_J2;
        end else begin
            return VENC_EMPATE;
        end
    endfunction

endpackage

// File: rtl/detector_borda.sv
// detector_borda
// Rising-edge detector with a one-cycle history register.
// Ports:
//   clock   - system clock, rising edge
//   reset   - asynchronous, active-low reset
//   entrada - level input (already synchronized)
//   borda   - high while entrada=1 and it was 0 on the previous cycle
module detector_borda (
    input  logic clock,
    input  logic reset,
    input  logic entrada,
    output logic borda
);

    logic hist_q;

    // History updates every cycle, so a level held high only counts once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hist_q <= 1'b0;
        end else begin
            hist_q <= entrada;
        end
    end

    assign borda = entrada & ~hist_q;

endmodule

// File: rtl/arbitro_jogadores.sv
// arbitro_jogadores
// Two-player turn scheduler: grants the shared datapath to one player per turn,
// forwards that player's move, enforces a per-turn timeout, keeps scores and
// rounds, and declares the winner.
// Ports:
//   clock, reset                 - clock (rising edge), async active-low reset
//   iniciar                      - start/restart a match (sampled in OCIOSO/FIM)
//   j1_fileira/coluna/jogou      - player 1 move and move-valid level
//   j2_fileira/coluna/jogou      - player 2 move and move-valid level
//   fd_pronto, fd_acertou        - datapath evaluation done / result
//   fd_nova                      - request new target square (pulse)
//   fd_fileira, fd_coluna        - forwarded move (registered)
//   fd_jogou                     - forwarded move strobe (pulse)
//   vez                          - 0 = player 1's turn, 1 = player 2's
//   pontos_j1, pontos_j2, rodada - scores and completed rounds
//   estourou                     - turn-timeout pulse
//   fim, vencedor                - match over, winner code
//   db_estado                    - current state code
module arbitro_jogadores
    import arbitro_pkg::*;
#(
    parameter int unsigned RODADAS        = 8,
    parameter int unsigned TIMEOUT_CICLOS = 5000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] j1_fileira,
    input  logic [3:0] j1_coluna,
    input  logic       j1_jogou,
    input  logic [3:0] j2_fileira,
    input  logic [3:0] j2_coluna,
    input  logic       j2_jogou,
    input  logic       fd_pronto,
    input  logic       fd_acertou,
    output logic       fd_nova,
    output logic [3:0] fd_fileira,
    output logic [3:0] fd_coluna,
    output logic       fd_jogou,
    output logic       vez,
    output logic [3:0] pontos_j1,
    output logic [3:0] pontos_j2,
    output logic [3:0] rodada,
    output logic       estourou,
    output logic       fim,
    output logic [1:0] vencedor,
    output logic [3:0] db_estado
);

    localparam int unsigned TW          = largura_timer(TIMEOUT_CICLOS);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CICLOS - 1);
    localparam logic [3:0] RODADAS_MAX  = 4'(RODADAS);

    logic [2:0]    estado_q, estado_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          vez_q, vez_d;
    logic [3:0]    pontos_j1_q, pontos_j1_d;
    logic [3:0]    pontos_j2_q, pontos_j2_d;
    logic [3:0]    rodada_q, rodada_d;
    logic [3:0]    fd_fileira_q, fd_fileira_d;
    logic [3:0]    fd_coluna_q, fd_coluna_d;
    logic          fd_nova_q, fd_nova_d;
    logic          fd_jogou_q, fd_jogou_d;
    logic          estourou_q, estourou_d;
    logic          fim_q, fim_d;
    logic [1:0]    vencedor_q, vencedor_d;

    logic borda_j1, borda_j2, borda_vez;

    detector_borda u_borda_j1 (
        .clock   (clock),
        .reset   (reset),
        .entrada (j1_jogou),
        .borda   (borda_j1)
    );

    detector_borda u_borda_j2 (
        .clock   (clock),
        .reset   (reset),
        .entrada (j2_jogou),
        .borda   (borda_j2)
    );

    // Only the player holding the turn is listened to.
    assign borda_vez = vez_q ? borda_j2 : borda_j1;

    always_comb begin
        estado_d     = estado_q;
        timer_d      = timer_q;
        vez_d        = vez_q;
        pontos_j1_d  = pontos_j1_q;
        pontos_j2_d  = pontos_j2_q;
        rodada_d     = rodada_q;
        fd_fileira_d = fd_fileira_q;
        fd_coluna_d  = fd_coluna_q;
        estourou_d   = 1'b0;

        case (estado_q)
            ST_OCIOSO, ST_FIM: begin
                if (iniciar) begin
                    pontos_j1_d = 4'd0;
                    pontos_j2_d = 4'd0;
                    rodada_d    = 4'd0;
                    vez_d       = 1'b0;
                    estado_d    = ST_NOVA;
                end
            end
            ST_NOVA: begin
                timer_d  = '0;
                estado_d = ST_ESPERA;
            end
            ST_ESPERA: begin
                // A move on the last timer cycle beats the timeout.
                if (borda_vez) begin
                    fd_fileira_d = vez_q ? j2_fileira : j1_fileira;
                    fd_coluna_d  = vez_q ? j2_coluna : j1_coluna;
                    estado_d     = ST_ENVIA;
                end else if (timer_q == TIMER_MAX) begin
                    estourou_d = 1'b1;
                    estado_d   = ST_PROXIMO;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_ENVIA: begin
                estado_d = ST_AVALIA;
            end
            ST_AVALIA: begin
                if (fd_pronto) begin
                    if (fd_acertou) begin
                        if (!vez_q && pontos_j1_q != 4'd15) begin
                            pontos_j1_d = pontos_j1_q + 4'd1;
                        end
                        if (vez_q && pontos_j2_q != 4'd15) begin
                            pontos_j2_d = pontos_j2_q + 4'd1;
                        end
                    end
                    estado_d = ST_PROXIMO;
                end
            end
            ST_PROXIMO: begin
                vez_d = ~vez_q;
                // A round completes once player 2 has had a turn.
                if (vez_q) begin
                    rodada_d = rodada_q + 4'd1;
                end
                estado_d = (rodada_d == RODADAS_MAX) ? ST_FIM : ST_NOVA;
            end
            default: begin
                estado_d = ST_OCIOSO;
            end
        endcase

        // Outputs derived from the next state so they are registered and aligned
        // with the state they belong to.
        fd_nova_d  = (estado_d == ST_NOVA);
        fd_jogou_d = (estado_d == ST_ENVIA);
        fim_d      = (estado_d == ST_FIM);
        vencedor_d = fim_d ? calcula_vencedor(pontos_j1_d, pontos_j2_d) : VENC_NENHUM;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q     <= ST_OCIOSO;
            timer_q      <= '0;
            vez_q        <= 1'b0;
            pontos_j1_q  <= 4'd0;
            pontos_j2_q  <= 4'd0;
            rodada_q     <= 4'd0;
            fd_fileira_q <= 4'd0;
            fd_coluna_q  <= 4'd0;
            fd_nova_q    <= 1'b0;
            fd_jogou_q   <= 1'b0;
            estourou_q   <= 1'b0;
            fim_q        <= 1'b0;
            vencedor_q   <= VENC_NENHUM;
        end else begin
            estado_q     <= estado_d;
            timer_q      <= timer_d;
            vez_q        <= vez_d;
            pontos_j1_q  <= pontos_j1_d;
            pontos_j2_q  <= pontos_j2_d;
            rodada_q     <= rodada_d;
            fd_fileira_q <= fd_fileira_d;
            fd_coluna_q  <= fd_coluna_d;
            fd_nova_q    <= fd_nova_d;
            fd_jogou_q   <= fd_jogou_d;
            estourou_q   <= estourou_d;
            fim_q        <= fim_d;
            vencedor_q   <= vencedor_d;
        end
    end

    assign fd_nova    = fd_nova_q;
    assign fd_fileira = fd_fileira_q;
    assign fd_coluna  = fd_coluna_q;
    assign fd_jogou   = fd_jogou_q;
    assign vez        = vez_q;
    assign pontos_j1  = pontos_j1_q;
    assign pontos_j2  = pontos_j2_q;
    assign rodada     = rodada_q;
    assign estourou   = estourou_q;
    assign fim        = fim_q;
    assign vencedor   = vencedor_q;
    assign db_estado  = {1'b0, estado_q};

endmodule

// File: tb/tb_arbitro_jogadores.sv
// tb_arbitro_jogadores
// Directed-vector bench for arbitro_jogadores with RODADAS=2, TIMEOUT_CICLOS=16.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_arbitro_jogadores;

    logic       clock;
    logic       reset;
    logic       iniciar;
    logic [3:0] j1_fileira, j1_coluna;
    logic       j1_jogou;
    logic [3:0] j2_fileira, j2_coluna;
    logic       j2_jogou;
    logic       fd_pronto, fd_acertou;
    logic       fd_nova;
    logic [3:0] fd_fileira, fd_coluna;
    logic       fd_jogou;
    logic       vez;
    logic [3:0] pontos_j1, pontos_j2, rodada;
    logic       estourou, fim;
    logic [1:0] vencedor;
    logic [3:0] db_estado;

    int total = 0;
    int bad   = 0;

    arbitro_jogadores #(
        .RODADAS        (2),
        .TIMEOUT_CICLOS (16)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .iniciar    (iniciar),
        .j1_fileira (j1_fileira),
        .j1_coluna  (j1_coluna),
        .j1_jogou   (j1_jogou),
        .j2_fileira (j2_fileira),
        .j2_coluna  (j2_coluna),
        .j2_jogou   (j2_jogou),
        .fd_pronto  (fd_pronto),
        .fd_acertou (fd_acertou),
        .fd_nova    (fd_nova),
        .fd_fileira (fd_fileira),
        .fd_coluna  (fd_coluna),
        .fd_jogou   (fd_jogou),
        .vez        (vez),
        .pontos_j1  (pontos_j1),
        .pontos_j2  (pontos_j2),
        .rodada     (rodada),
        .estourou   (estourou),
        .fim        (fim),
        .vencedor   (vencedor),
        .db_estado  (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        total++;
        if (obs !== esp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
        end
    endtask

    // Full turn starting in NOVA: move-valid edge, evaluation with given result.
    task automatic jogada(input logic jog, input logic [3:0] f, input logic [3:0] c,
                          input logic acerta);
        if (!jog) begin
            j1_jogou = 1'b0; j1_fileira = f; j1_coluna = c;
        end else begin
            j2_jogou = 1'b0; j2_fileira = f; j2_coluna = c;
        end
        tick;
        verifica("turno_espera", db_estado, 4'd2);
        if (!jog) j1_jogou = 1'b1; else j2_jogou = 1'b1;
        tick;
        verifica("turno_envia", db_estado, 4'd3);
        verifica("turno_fd_jogou", fd_jogou, 1'b1);
        verifica("turno_fileira", fd_fileira, f);
        verifica("turno_coluna", fd_coluna, c);
        if (!jog) j1_jogou = 1'b0; else j2_jogou = 1'b0;
        tick;
        verifica("turno_avalia", db_estado, 4'd4);
        fd_pronto = 1'b1; fd_acertou = acerta;
        tick;
        verifica("turno_proximo", db_estado, 4'd5);
        fd_pronto = 1'b0; fd_acertou = 1'b0;
        tick;
    endtask

    initial begin
        reset = 1'b0; iniciar = 1'b0;
        j1_fileira = 4'd0; j1_coluna = 4'd0; j1_jogou = 1'b0;
        j2_fileira = 4'd0; j2_coluna = 4'd0; j2_jogou = 1'b0;
        fd_pronto = 1'b0; fd_acertou = 1'b0;
        tick; tick;
        verifica("rst_estado", db_estado, 4'd0);
        verifica("rst_fd_nova", fd_nova, 1'b0);
        verifica("rst_vez", vez, 1'b0);
        verifica("rst_pontos", {pontos_j1, pontos_j2}, 8'd0);
        verifica("rst_fim_venc", {fim, vencedor}, 3'd0);
        reset = 1'b1;
        tick;
        verifica("ocioso_hold", db_estado, 4'd0);

        // Match 1: start
        iniciar = 1'b1;
        tick;
        verifica("ini_estado", db_estado, 4'd1);
        verifica("ini_fd_nova", fd_nova, 1'b1);
        verifica("ini_vez", vez, 1'b0);
        iniciar = 1'b0;
        tick;
        verifica("espera_estado", db_estado, 4'd2);
        verifica("espera_fd_nova", fd_nova, 1'b0);

        // Both players raise move-valid; only J1 counts
        j1_fileira = 4'd3; j1_coluna = 4'd5; j1_jogou = 1'b1;
        j2_fileira = 4'd1; j2_coluna = 4'd1; j2_jogou = 1'b1;
        tick;
        verifica("j1_envia", db_estado, 4'd3);
        verifica("j1_fd_jogou", fd_jogou, 1'b1);
        verifica("j1_fileira", fd_fileira, 4'd3);
        verifica("j1_coluna", fd_coluna, 4'd5);
        tick;
        verifica("j1_avalia", db_estado, 4'd4);
        verifica("j1_fd_jogou_pulso", fd_jogou, 1'b0);
        fd_pronto = 1'b1; fd_acertou = 1'b1;
        tick;
        verifica("j1_proximo", db_estado, 4'd5);
        verifica("j1_pontos", pontos_j1, 4'd1);
        fd_pronto = 1'b0; fd_acertou = 1'b0;
        tick;
        verifica("j2_nova", db_estado, 4'd1);
        verifica("j2_vez", vez, 1'b1);
        verifica("j2_rodada0", rodada, 4'd0);

        // J2 idle (j2_jogou still held high: no new edge); stray fd_pronto ignored
        tick;
        for (int i = 2; i <= 16; i++) begin
            fd_pronto = (i == 5);
            tick;
        end
        fd_pronto = 1'b0;
        verifica("idle_ciclo16", db_estado, 4'd2);
        verifica("idle_sem_estouro", estourou, 1'b0);
        tick;
        verifica("estouro_estado", db_estado, 4'd5);
        verifica("estouro_pulso", estourou, 1'b1);
        verifica("estouro_pontos_j2", pontos_j2, 4'd0);
        tick;
        verifica("r2_nova", db_estado, 4'd1);
        verifica("r2_rodada", rodada, 4'd1);
        verifica("r2_vez", vez, 1'b0);
        verifica("estouro_fim_pulso", estourou, 1'b0);

        // Round 2, J1 scores again
        jogada(1'b0, 4'd7, 4'd2, 1'b1);
        verifica("r2_j1_pontos", pontos_j1, 4'd2);
        verifica("r2_j2_vez", vez, 1'b1);

        // J2 moves on the very cycle the timer expires
        j2_jogou = 1'b0;
        tick;
        for (int i = 2; i <= 16; i++) tick;
        verifica("limite_espera", db_estado, 4'd2);
        j2_fileira = 4'd4; j2_coluna = 4'd4; j2_jogou = 1'b1;
        tick;
        verifica("limite_envia", db_estado, 4'd3);
        verifica("limite_sem_estouro", estourou, 1'b0);
        verifica("limite_fileira", fd_fileira, 4'd4);
        j2_jogou = 1'b0;
        tick;
        fd_pronto = 1'b1; fd_acertou = 1'b1;
        tick;
        verifica("limite_pontos_j2", pontos_j2, 4'd1);
        fd_pronto = 1'b0; fd_acertou = 1'b0;
        tick;
        verifica("fim_estado", db_estado, 4'd6);
        verifica("fim_flag", fim, 1'b1);
        verifica("fim_vencedor", vencedor, 2'b01);
        verifica("fim_rodada", rodada, 4'd2);
        tick; tick;
        verifica("fim_hold", {db_estado, pontos_j1, pontos_j2}, {4'd6, 4'd2, 4'd1});

        // Match 2: restart from FIM, finish tied 1-1
        iniciar = 1'b1;
        tick;
        iniciar = 1'b0;
        verifica("reini_estado", db_estado, 4'd1);
        verifica("reini_zera", {pontos_j1, pontos_j2, rodada}, 12'd0);
        verifica("reini_fim", {fim, vencedor, vez}, 4'd0);
        jogada(1'b0, 4'd1, 4'd2, 1'b1);
        jogada(1'b1, 4'd3, 4'd4, 1'b1);
        jogada(1'b0, 4'd5, 4'd6, 1'b0);
        jogada(1'b1, 4'd7, 4'd8, 1'b0);
        verifica("empate_estado", db_estado, 4'd6);
        verifica("empate_vencedor", vencedor, 2'b11);

        // Match 3: reset while waiting in AVALIA
        iniciar = 1'b1;
        tick;
        iniciar = 1'b0;
        j1_fileira = 4'd9; j1_coluna = 4'd10; j1_jogou = 1'b0;
        tick;
        j1_jogou = 1'b1;
        tick;
        j1_jogou = 1'b0;
        tick;
        verifica("rst_av_avalia", db_estado, 4'd4);
        reset = 1'b0;
        #1;
        verifica("rst_av_estado", db_estado, 4'd0);
        verifica("rst_av_coord", {fd_fileira, fd_coluna}, 8'd0);
        verifica("rst_av_pulsos", {fd_nova, fd_jogou, estourou, fim, vencedor, vez}, 7'd0);
        tick;
        reset = 1'b1;
        tick;
        verifica("rst_av_ocioso", db_estado, 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arbitro_jogadores.md
# arbitro_jogadores

Two-player turn scheduler for the chessLab board datapath. Two players share one datapath and one set of move inputs into it. This block grants the datapath to one player per turn, forwards that player's move, and enforces a per-turn time limit. It also keeps per-player scores and rounds, and declares the winner. It sits between the two player input panels and `proj_fluxo_dados`, in the same top level as the game controller.

## Interface
Parameters:
- `RODADAS`, 8: turns per player in a match (1–15)
- `TIMEOUT_CICLOS`, 5000: clock cycles allowed per turn (≥2)

Ports:
- `clock`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `iniciar`  in  1  start or restart a match (level; sampled in OCIOSO/FIM only)
- `j1_fileira`, `j1_coluna`  in  4 each  player 1 move
- `j1_jogou`  in  1  player 1 move-valid (already synchronized; rising edge counts)
- `j2_fileira`, `j2_coluna`, `j2_jogou`  in  4/4/1  player 2, same rules
- `fd_pronto`  in  1  datapath finished evaluating the forwarded move (1-cycle pulse)
- `fd_acertou`  in  1  evaluation result, valid with `fd_pronto`
- `fd_nova`  out  1  request new target square (1-cycle pulse)
- `fd_fileira`, `fd_coluna`  out  4 each  forwarded move, registered
- `fd_jogou`  out  1  forwarded move strobe (1-cycle pulse)
- `vez`  out  1  0 = player 1's turn, 1 = player 2's
- `pontos_j1`, `pontos_j2`  out  4 each  scores (binary)
- `rodada`  out  4  completed rounds
- `estourou`  out  1  turn-timeout pulse (1 cycle)
- `fim`  out  1  match over
- `vencedor`  out  2  00 none, 01 J1, 10 J2, 11 tie (valid while `fim`)
- `db_estado`  out  4  state code

## Operation
- States and codes:
  - OCIOSO=0
  - NOVA=1
  - ESPERA=2
  - ENVIA=3
  - AVALIA=4
  - PROXIMO=5
  - FIM=6
- Reset state: OCIOSO. Every output is 0 at reset.
- OCIOSO: `iniciar`=1 → clear scores, `rodada`, `vez` → NOVA.
- NOVA:
  - pulse `fd_nova` and clear the turn timer.
  - → ESPERA.
- ESPERA:
  - Only the current player's `jN_jogou` rising edge counts. The other player's inputs are ignored.
  - On that edge, latch that player's fileira/coluna into `fd_fileira`/`fd_coluna` → ENVIA.
  - Timer reaches `TIMEOUT_CICLOS`-1 with no edge → pulse `estourou`, no score change → PROXIMO.
  - Edge and timeout in the same cycle: the move wins.
- ENVIA: pulse `fd_jogou` → AVALIA. `fd_fileira`/`fd_coluna` stay stable until the next latch.
- AVALIA:
  - Wait for `fd_pronto`, with no time limit.
  - On `fd_pronto` with `fd_acertou`=1, increment the current player's score. Scores saturate at 15.
  - → PROXIMO.
- `fd_pronto` in any state other than AVALIA is ignored.
- PROXIMO:
  - Toggle `vez`.
  - If `vez` was 1 (J2 just played), increment `rodada`.
  - `rodada` reaches `RODADAS` → FIM; otherwise → NOVA.
- FIM:
  - `fim`=1.
  - `vencedor` = the higher score, 11 on equal scores.
  - Scores and `rodada` hold.
  - `iniciar`=1 → clear scores, `rodada`, `vez` → NOVA.
- `iniciar` outside OCIOSO and FIM is ignored.
- Edge detection uses a 1-cycle history register per player. The history register updates every cycle in every state, so a level held across turns does not count again.
- A `reset` assertion at any time returns the block to OCIOSO immediately and clears all registers and outputs.

## Timing
- All outputs are registered. Pulses last exactly 1 cycle.
- Latencies:
  - `iniciar` high in OCIOSO at edge k → `fd_nova`=1 during cycle k+1.
  - Player edge seen at edge k → `fd_jogou`=1 during cycle k+1, with coordinates already valid.
  - `fd_pronto` at edge k → score updated and PROXIMO during cycle k+1 → NOVA or FIM during cycle k+2.
- Timeout: with no move, ESPERA lasts exactly `TIMEOUT_CICLOS` cycles.
- `vez`, `rodada` and scores change only on the PROXIMO/AVALIA edges described above.

## Structure
- Shared package `arbitro_pkg` holds:
  - state codes
  - `vencedor` codes
  - the timer width `$clog2(TIMEOUT_CICLOS)`
- Sub-module `detector_borda` (rising-edge detector with asynchronous active-low reset), instantiated once per player.
- FSM, turn timer, score counters and round counter live in the top-level body.

## Test plan
- Reset then `iniciar` → `fd_nova` pulse; `vez`=0; `db_estado` goes 0→1→2.
- J1 plays (3,5) while J2 plays (1,1) in the same turn → `fd_fileira`=3, `fd_coluna`=5, one `fd_jogou`. `fd_pronto`+`fd_acertou` → `pontos_j1`=1, `vez`=1.
- J2 idle for `TIMEOUT_CICLOS`=16 cycles → `estourou` pulse on cycle 16 of ESPERA; `pontos_j2`=0; `rodada`=1.
- `RODADAS`=2, J1 scores twice, J2 once → `fim`=1, `vencedor`=01, `db_estado`=6. Equal scores → `vencedor`=11.
- Player edge on the same cycle as timeout expiry → move forwarded, no `estourou`.
- Reset asserted in AVALIA, and `iniciar` in FIM → all outputs 0 and state 0; `iniciar` in FIM clears scores and restarts at NOVA.
